// File: rtl/usb_transaction_fsm.sv
// Host-side USB transaction engine: token, data/handshake exchange, retry on
// NAK/timeout/corruption, and success/failure reporting to the sequencer.
module usb_transaction_fsm #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        out_trans,
  input  logic        in_trans,
  input  logic [6:0]  dev_addr,
  input  logic [3:0]  endp,
  input  logic [63:0] data_out,
  output logic [63:0] data_in,
  output logic        busy,
  output logic        trans_done,
  output logic        trans_fail,
  output logic        pkt_send,
  output logic [3:0]  pkt_pid,
  output logic [10:0] pkt_token,
  output logic [63:0] pkt_data,
  input  logic        enc_done,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_err
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_DATA, S_WAIT_HS, S_RXDATA,
    S_SEND_ACK, S_RETRY, S_DONE, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic          is_in_q, is_in_d;
  logic [10:0]   token_q, token_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   din_q, din_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          sent_q, sent_d;
  logic          tmo_expired;

  assign tmo_expired = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      is_in_q <= 1'b0;
      token_q <= '0;
      data_q  <= '0;
      din_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_in_q <= is_in_d;
      token_q <= token_d;
      data_q  <= data_d;
      din_q   <= din_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_in_d = is_in_q;
    token_d = token_q;
    data_d  = data_q;
    din_d   = din_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (out_trans || in_trans) begin
          state_d = S_TOKEN;
          is_in_d = !out_trans;
          token_d = {endp, dev_addr};
          data_d  = data_out;
        end
      end
      S_TOKEN:    if (enc_done) state_d = is_in_q ? S_RXDATA : S_DATA;
      S_DATA:     if (enc_done) state_d = S_WAIT_HS;
      S_WAIT_HS: begin
        if (rx_valid) begin
          state_d = (!rx_err && rx_pid == PID_ACK) ? S_DONE : S_RETRY;
        end else if (tmo_expired) begin
          state_d = S_RETRY;
        end
      end
      S_RXDATA: begin
        if (rx_valid) begin
          if (!rx_err && rx_pid == PID_DATA0) begin
            din_d   = rx_data;
            state_d = S_SEND_ACK;
          end else begin
            state_d = S_RETRY;
          end
        end else if (tmo_expired) begin
          state_d = S_RETRY;
        end
      end
      S_SEND_ACK: if (enc_done) state_d = S_DONE;
      S_RETRY: begin
        retry_d = retry_q + RW'(1);
        state_d = (retry_d == RW'(MAX_RETRY)) ? S_FAIL : S_TOKEN;
      end
      S_DONE, S_FAIL: begin
        retry_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any state change restarts the response window and re-arms the send pulse.
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == S_WAIT_HS || state_q == S_RXDATA) begin
      tmo_d = tmo_q + TW'(1);
    end
    sent_d = (state_d != state_q) ? 1'b0 : (sent_q | pkt_send);
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    trans_done = (state_q == S_DONE);
    trans_fail = (state_q == S_FAIL);
    pkt_send   = 1'b0;
    pkt_pid    = '0;
    case (state_q)
      S_TOKEN: begin
        pkt_send = !sent_q;
        pkt_pid  = is_in_q ? PID_IN : PID_OUT;
      end
      S_DATA: begin
        pkt_send = !sent_q;
        pkt_pid  = PID_DATA0;
      end
      S_SEND_ACK: begin
        pkt_send = !sent_q;
        pkt_pid  = PID_ACK;
      end
      default: ;
    endcase
    pkt_token = token_q;
    pkt_data  = data_q;
    data_in   = din_q;
  end

endmodule

// File: doc/usb_transaction_fsm.md
Name: usb_transaction_fsm

Overview:
- Host-side transaction engine directly downstream of the read/write sequencer.
- Executes one USB OUT or IN transaction per request: token packet, then either a data stage plus handshake wait (OUT) or a data receive plus ACK (IN).
- Drives the packet encoder and consumes the packet decoder output.
- Handles NAK, timeout and corrupted packets by retrying up to a limit, then reports success or failure to the sequencer.

Parameters:
- TIMEOUT, 255, cycles to wait for a device response before the attempt counts as failed.
- MAX_RETRY, 8, total attempts (first try included) before trans_fail.

Ports:
- clk  in  1  system clock
- rst_b  in  1  reset; asynchronous, active-low
- out_trans  in  1  start OUT transaction (sampled in IDLE only)
- in_trans  in  1  start IN transaction (sampled in IDLE only)
- dev_addr  in  7  device address for token
- endp  in  4  endpoint for token
- data_out  in  64  OUT payload, captured at request acceptance
- data_in  out  64  IN payload, valid from the trans_done pulse until the next accepted request
- busy  out  1  high from acceptance until the done/fail pulse inclusive
- trans_done  out  1  one-cycle pulse, transaction succeeded
- trans_fail  out  1  one-cycle pulse, retries exhausted
- pkt_send  out  1  one-cycle pulse, encoder starts a packet
- pkt_pid  out  4  PID of the packet being sent
- pkt_token  out  11  {endp, dev_addr}; meaningful for token packets
- pkt_data  out  64  payload for DATA0 packets
- enc_done  in  1  encoder finished the current packet (one-cycle pulse)
- rx_valid  in  1  decoder delivered a packet (one-cycle pulse)
- rx_pid  in  4  received PID
- rx_data  in  64  received payload
- rx_err  in  1  CRC, bit-stuff or PID-check error on the received packet; qualified by rx_valid

Behaviour:
- PIDs: OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010. All data packets use DATA0; no toggle tracking.
- Reset values: all outputs 0, state IDLE, retry count 0, timeout count 0.
- Request acceptance:
  - IDLE only; out_trans has priority if both are high.
  - Requests arriving while busy are ignored.
  - On acceptance, capture dev_addr, endp and data_out, and set busy the next cycle.
- pkt_pid, pkt_token and pkt_data are set in the cycle pkt_send pulses and held stable until enc_done.
- States:
  - IDLE: wait for a request.
  - TOKEN: pulse pkt_send with pkt_pid = OUT or IN; wait for enc_done. Then go to DATA for OUT, or RXDATA for IN.
  - DATA (OUT): pulse pkt_send with DATA0 and the captured payload; on enc_done go to WAIT_HS.
  - WAIT_HS (OUT): on rx_valid with rx_err=0:
    - rx_pid = ACK goes to DONE.
    - NAK or any other PID goes to RETRY.
    - rx_err=1 or timeout goes to RETRY.
  - RXDATA (IN): on rx_valid with rx_err=0:
    - rx_pid = DATA0: latch rx_data into data_in, go to SEND_ACK.
    - NAK or any other PID goes to RETRY.
    - rx_err=1 or timeout goes to RETRY, and no handshake is sent.
  - SEND_ACK: pulse pkt_send with ACK; on enc_done go to DONE.
  - RETRY: increment the retry count. If the count equals MAX_RETRY, go to FAIL; otherwise return to TOKEN. The captured fields are unchanged.
  - DONE / FAIL: pulse trans_done or trans_fail for one cycle, clear the retry count, return to IDLE; busy drops the following cycle.
- Timeout counter:
  - Cleared on entry to WAIT_HS or RXDATA, and increments each cycle there.
  - Expires when it reaches TIMEOUT-1.
  - rx_valid in the expiry cycle takes precedence over the timeout.
- rx_valid outside WAIT_HS/RXDATA is ignored. enc_done outside the send states is ignored.
- Width rules: retry count is clog2(MAX_RETRY+1) bits; timeout count is clog2(TIMEOUT+1) bits.
- Asynchronous reset mid-transaction:
  - Immediate return to IDLE, outputs cleared.
  - No done or fail pulse.
  - Any partially sent packet is the encoder's responsibility.

Test Plan:
- OUT, addr=7'h05, endp=4'h1, data_out=64'hDEADBEEF_01234567; device ACKs. Required:
  - token pulse with pkt_token=11'h085;
  - DATA0 pulse carrying the payload;
  - one trans_done pulse; busy low afterwards.
- IN; decoder returns DATA0 with rx_data=64'hCAFEF00D_11223344. Required:
  - ACK sent;
  - data_in equals the payload at trans_done.
- OUT; device NAKs twice, then ACKs. Required: exactly 3 token packets, one trans_done, no trans_fail.
- IN; no response at all. Required: 8 IN tokens each separated by a TIMEOUT-cycle wait, then one trans_fail pulse, data_in unchanged.
- IN; DATA0 arrives with rx_err=1, then a clean DATA0 on the retry. Required: no ACK after the bad packet; ACK and trans_done after the good one.
- Edge cases:
  - out_trans and in_trans high together: an OUT token is sent.
  - new requests while busy are ignored.
  - rst_b asserted during WAIT_HS: all outputs 0 at once, no pulse; a new request after release is accepted normally.
